exc_commit_ctrl: RTL and testbench

//  Exception/interrupt commit controller: producer side of the CP0 exception interface.
//  - Watches the commit-stage instruction and samples the CP0 interrupt state.
//  - Issues a single-cycle exception or ERET request to CP0.
//  - Captures CP0's returned redirect PC, flushes the pipeline and hands the redirect to fetch (valid/ready).

---
 rtl/exc_commit_ctrl_if.sv | 46 ++++
 rtl/exc_commit_ctrl.sv | 156 +++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// +----------------------------------------------------------------------+
// | exc_commit_ctrl_if : commit-stage, CP0 and fetch-redirect signals     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface exc_commit_ctrl_if;
    logic        ms_valid;
    logic        ms_ready;
    logic [31:0] ms_pc;
    logic        ms_bd;
    logic        ms_ex;
    logic [4:0]  ms_excode;
    logic [31:0] ms_badvaddr;
    logic        ms_eret;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        cp0_ex_t;
    logic [4:0]  cp0_excode_t;
    logic [31:0] cp0_pc;
    logic        cp0_bd;
    logic [31:0] cp0_badvaddr;
    logic        eret_flush;
    logic        int_flush;
    logic [31:0] int_pc;
    logic        pipe_flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    modport master (
        input  ms_valid, ms_pc, ms_bd, ms_ex, ms_excode, ms_badvaddr, ms_eret,
        input  cp0_status, cp0_cause, int_flush, int_pc, redir_ready,
        output ms_ready, cp0_ex_t, cp0_excode_t, cp0_pc, cp0_bd, cp0_badvaddr,
        output eret_flush, pipe_flush, redir_valid, redir_pc
    );

    modport slave (
        output ms_valid, ms_pc, ms_bd, ms_ex, ms_excode, ms_badvaddr, ms_eret,
        output cp0_status, cp0_cause, int_flush, int_pc, redir_ready,
        input  ms_ready, cp0_ex_t, cp0_excode_t, cp0_pc, cp0_bd, cp0_badvaddr,
        input  eret_flush, pipe_flush, redir_valid, redir_pc
    );
endinterface

`default_nettype wire

// File: rtl/exc_commit_ctrl.sv
// +----------------------------------------------------------------------+
// | exc_commit_ctrl : exception/interrupt commit controller feeding CP0   |
// | and the fetch redirect. Optional counters under EXC_STAT_EN.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module exc_commit_ctrl #(
    parameter int STAT_W = 16
) (
    input  wire                  clk,
    input  wire                  resetn,
    exc_commit_ctrl_if.master    bus
`ifdef EXC_STAT_EN
    ,
    input  wire                  stat_clr,
    output logic [STAT_W-1:0]    stat_exc,
    output logic [STAT_W-1:0]    stat_int
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_REDIR  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_ready;
    logic        w_int_take;
    logic        w_trig;

    logic        r_is_int;
    logic        r_is_eret;
    logic [4:0]  r_excode;
    logic [31:0] r_pc;
    logic        r_bd;
    logic [31:0] r_badvaddr;
    logic [31:0] r_redir_pc;

    assign w_ready    = (r_state == S_IDLE);
    assign w_int_take = bus.cp0_status[0] & ~bus.cp0_status[1]
                      & (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]));
    assign w_trig     = bus.ms_valid & w_ready & (w_int_take | bus.ms_ex | bus.ms_eret);

    // int_flush is informational: the redirect target is captured regardless.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{bus.int_flush, bus.cp0_status[31:16], bus.cp0_status[7:2],
                               bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_trig) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_REDIR;
            S_REDIR:  if (bus.redir_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Priority: interrupt, then synchronous exception, then ERET.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_int   <= 1'b0;
            r_is_eret  <= 1'b0;
            r_excode   <= 5'd0;
            r_pc       <= 32'd0;
            r_bd       <= 1'b0;
            r_badvaddr <= 32'd0;
        end else if (w_trig) begin
            r_is_int   <= w_int_take;
            r_is_eret  <= ~w_int_take & ~bus.ms_ex & bus.ms_eret;
            r_excode   <= (~w_int_take & bus.ms_ex) ? bus.ms_excode : 5'd0;
            r_pc       <= (w_int_take | bus.ms_ex) ? bus.ms_pc : 32'd0;
            r_bd       <= (w_int_take | bus.ms_ex) ? bus.ms_bd : 1'b0;
            r_badvaddr <= (~w_int_take & bus.ms_ex) ? bus.ms_badvaddr : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redir_pc <= 32'd0;
        end else if (r_state == S_COMMIT) begin
            r_redir_pc <= bus.int_pc;
        end
    end

    always_comb begin
        bus.ms_ready     = w_ready;
        bus.cp0_ex_t     = 1'b0;
        bus.eret_flush   = 1'b0;
        bus.cp0_excode_t = 5'd0;
        bus.cp0_pc       = 32'd0;
        bus.cp0_bd       = 1'b0;
        bus.cp0_badvaddr = 32'd0;
        bus.pipe_flush   = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_pc     = r_redir_pc;
        case (r_state)
            S_COMMIT: begin
                bus.cp0_ex_t     = ~r_is_eret;
                bus.eret_flush   = r_is_eret;
                bus.cp0_excode_t = r_excode;
                bus.cp0_pc       = r_pc;
                bus.cp0_bd       = r_bd;
                bus.cp0_badvaddr = r_badvaddr;
                bus.pipe_flush   = 1'b1;
            end
            S_REDIR: begin
                bus.pipe_flush   = 1'b1;
                bus.redir_valid  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef EXC_STAT_EN
    logic              w_stat_exc_inc;
    logic              w_stat_int_inc;
    logic [STAT_W-1:0] r_stat_exc;
    logic [STAT_W-1:0] r_stat_int;

    assign w_stat_exc_inc = (r_state == S_COMMIT) & ~r_is_eret & (r_excode != 5'd0);
    assign w_stat_int_inc = (r_state == S_COMMIT) & r_is_int;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_exc <= '0;
            r_stat_int <= '0;
        end else if (stat_clr) begin
            r_stat_exc <= '0;
            r_stat_int <= '0;
        end else begin
            if (w_stat_exc_inc) r_stat_exc <= r_stat_exc + 1'b1;
            if (w_stat_int_inc) r_stat_int <= r_stat_int + 1'b1;
        end
    end

    assign stat_exc = r_stat_exc;
    assign stat_int = r_stat_int;
`else
    logic w_unused_stat_w;
    assign w_unused_stat_w = (STAT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_exc_commit_ctrl : scoreboard bench for exc_commit_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_exc_commit_ctrl;

    typedef struct packed {
        logic        ex;
        logic        eret;
        logic [4:0]  excode;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bva;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    exc_commit_ctrl_if bus ();

`ifdef EXC_STAT_EN
    logic       stat_clr = 1'b0;
    logic       clr_at_commit = 1'b0;
    logic [1:0] stat_exc;
    logic [1:0] stat_int;
    exc_commit_ctrl #(.STAT_W(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .stat_clr (stat_clr),
        .stat_exc (stat_exc),
        .stat_int (stat_int)
    );
`else
    exc_commit_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic ex, input logic eret, input logic [4:0] code,
                                   input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                                   input logic [31:0] st, input logic [31:0] ca);
        exp_t m;
        logic it;
        it = st[0] & ~st[1] & (|(st[15:8] & ca[15:8]));
        m  = '0;
        if (it) begin
            m.ex = 1'b1; m.pc = pc; m.bd = bd;
        end else if (ex) begin
            m.ex = 1'b1; m.excode = code; m.pc = pc; m.bd = bd; m.bva = bva;
        end else if (eret) begin
            m.eret = 1'b1;
        end
        return m;
    endfunction

    // CP0 request monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && mon_en) begin
            if (bus.cp0_ex_t || bus.eret_flush) begin
                if (sb.size() == 0) begin
                    chk("unexpected_req", {30'd0, bus.cp0_ex_t, bus.eret_flush}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("req_ex",     {31'd0, bus.cp0_ex_t},     {31'd0, mon_e.ex});
                    chk("req_eret",   {31'd0, bus.eret_flush},   {31'd0, mon_e.eret});
                    chk("req_excode", {27'd0, bus.cp0_excode_t}, {27'd0, mon_e.excode});
                    chk("req_pc",     bus.cp0_pc,                mon_e.pc);
                    chk("req_bd",     {31'd0, bus.cp0_bd},       {31'd0, mon_e.bd});
                    chk("req_bva",    bus.cp0_badvaddr,          mon_e.bva);
                end
            end else begin
                chk("idle_cp0_data", {31'd0, (|{bus.cp0_excode_t, bus.cp0_pc, bus.cp0_bd,
                                               bus.cp0_badvaddr})}, 32'd0);
            end
        end
    end

    task automatic drive(input logic ex, input logic eret, input logic [4:0] code,
                         input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                         input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ipc);
        bus.ms_valid    = 1'b1;
        bus.ms_ex       = ex;
        bus.ms_eret     = eret;
        bus.ms_excode   = code;
        bus.ms_pc       = pc;
        bus.ms_bd       = bd;
        bus.ms_badvaddr = bva;
        bus.cp0_status  = st;
        bus.cp0_cause   = ca;
        bus.int_pc      = ipc;
        bus.int_flush   = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic ex, input logic eret, input logic [4:0] code,
                           input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                           input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ipc,
                           input int stall);
        chk({tag, "_ready_pre"}, {31'd0, bus.ms_ready}, 32'd1);
        drive(ex, eret, code, pc, bd, bva, st, ca, ipc);
        sb.push_back(model(ex, eret, code, pc, bd, bva, st, ca));
        bus.redir_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ms_valid = 1'b0;
        bus.ms_ex    = 1'b0;
        bus.ms_eret  = 1'b0;
`ifdef EXC_STAT_EN
        stat_clr = clr_at_commit;
`endif
        chk({tag, "_commit_flush"}, {31'd0, bus.pipe_flush},  32'd1);
        chk({tag, "_commit_ready"}, {31'd0, bus.ms_ready},    32'd0);
        chk({tag, "_commit_rv"},    {31'd0, bus.redir_valid}, 32'd0);
        @(negedge clk);
`ifdef EXC_STAT_EN
        stat_clr = 1'b0;
`endif
        chk({tag, "_sb_drained"}, sb.size(), 32'd0);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_redir_valid"}, {31'd0, bus.redir_valid}, 32'd1);
            chk({tag, "_redir_pc"},    bus.redir_pc,             ipc);
            chk({tag, "_redir_flush"}, {31'd0, bus.pipe_flush},  32'd1);
            chk({tag, "_redir_ready"}, {31'd0, bus.ms_ready},    32'd0);
        end
        bus.redir_ready = 1'b1;
        @(negedge clk);
        bus.redir_ready = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, bus.ms_ready},    32'd1);
        chk({tag, "_idle_rv"},    {31'd0, bus.redir_valid}, 32'd0);
        chk({tag, "_idle_flush"}, {31'd0, bus.pipe_flush},  32'd0);
    endtask

    task automatic no_trig(input string tag, input logic valid, input logic [31:0] st,
                           input logic [31:0] ca);
        drive(1'b0, 1'b0, 5'd0, 32'h8000_0200, 1'b0, 32'd0, st, ca, 32'h8000_0300);
        bus.ms_valid = valid;
        @(posedge clk);
        @(negedge clk);
        bus.ms_valid = 1'b0;
        chk(tag, {31'd0, bus.ms_ready}, 32'd1);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.ms_valid    = 1'b0;
        bus.ms_ex       = 1'b0;
        bus.ms_eret     = 1'b0;
        bus.ms_excode   = 5'd0;
        bus.ms_pc       = 32'd0;
        bus.ms_bd       = 1'b0;
        bus.ms_badvaddr = 32'd0;
        bus.cp0_status  = 32'd0;
        bus.cp0_cause   = 32'd0;
        bus.int_flush   = 1'b0;
        bus.int_pc      = 32'd0;
        bus.redir_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",    {31'd0, bus.ms_ready},    32'd1);
        chk("rst_ex_t",     {31'd0, bus.cp0_ex_t},    32'd0);
        chk("rst_eret",     {31'd0, bus.eret_flush},  32'd0);
        chk("rst_flush",    {31'd0, bus.pipe_flush},  32'd0);
        chk("rst_rv",       {31'd0, bus.redir_valid}, 32'd0);
        chk("rst_redir_pc", bus.redir_pc,             32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.ms_ready}, 32'd1);
        mon_en = 1'b1;

        run_txn("adel",    1, 0, 5'h04, 32'hBFC0_0100, 0, 32'h0000_0003, 32'd0, 32'd0, 32'hBFC0_0380, 0);
        run_txn("adel_bp", 1, 0, 5'h04, 32'hBFC0_0100, 1, 32'h0000_0003, 32'd0, 32'd0, 32'hBFC0_0380, 3);
        run_txn("eret",    0, 1, 5'h00, 32'h8000_0040, 0, 32'd0,         32'd0, 32'd0, 32'h8000_1234, 0);
        run_txn("int_win", 1, 0, 5'h0a, 32'h8000_0100, 1, 32'h0000_0055,
                32'h0000_8001, 32'h0000_8000, 32'h8000_0180, 1);
        run_txn("exl_blk", 1, 0, 5'h0a, 32'h8000_0104, 0, 32'h0000_0055,
                32'h0000_8003, 32'h0000_8000, 32'h8000_0180, 0);
        run_txn("ex_eret", 1, 1, 5'h0c, 32'h8000_0108, 0, 32'h0000_0077,
                32'd0, 32'd0, 32'h8000_0380, 2);

        no_trig("plain_no_trig", 1'b1, 32'd0,         32'd0);
        no_trig("ie0_no_trig",   1'b1, 32'h0000_8000, 32'h0000_8000);
        no_trig("im_no_trig",    1'b1, 32'h0000_0401, 32'h0000_8000);
        no_trig("pend_invalid",  1'b0, 32'h0000_0401, 32'h0000_0400);
        no_trig("pend_invalid2", 1'b0, 32'h0000_0401, 32'h0000_0400);
        run_txn("pend_take", 0, 0, 5'h00, 32'h8000_0400, 0, 32'd0,
                32'h0000_0401, 32'h0000_0400, 32'h8000_0180, 0);

        // Reset while the redirect is outstanding.
        drive(1, 0, 5'h05, 32'h8000_0500, 0, 32'h0000_0011, 32'd0, 32'd0, 32'h8000_0380);
        sb.push_back(model(1, 0, 5'h05, 32'h8000_0500, 0, 32'h0000_0011, 32'd0, 32'd0));
        @(posedge clk);
        @(negedge clk);
        bus.ms_valid = 1'b0;
        bus.ms_ex    = 1'b0;
        @(negedge clk);
        chk("rif_redir_valid", {31'd0, bus.redir_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rif_rv_cleared",    {31'd0, bus.redir_valid}, 32'd0);
        chk("rif_flush_cleared", {31'd0, bus.pipe_flush},  32'd0);
        chk("rif_pc_cleared",    bus.redir_pc,             32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rif_ready_after", {31'd0, bus.ms_ready}, 32'd1);

`ifdef EXC_STAT_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr_exc", {30'd0, stat_exc}, 32'd0);
        chk("stat_clr_int", {30'd0, stat_int}, 32'd0);
        for (int k = 0; k < 5; k++)
            run_txn("stat_adel", 1, 0, 5'h04, 32'hBFC0_0100, 0, 32'h3, 32'd0, 32'd0, 32'hBFC0_0380, 0);
        chk("stat_exc_wrap", {30'd0, stat_exc}, 32'd1);
        clr_at_commit = 1'b1;
        run_txn("stat_clr_inc", 1, 0, 5'h04, 32'hBFC0_0100, 0, 32'h3, 32'd0, 32'd0, 32'hBFC0_0380, 0);
        clr_at_commit = 1'b0;
        chk("stat_exc_clr_pri", {30'd0, stat_exc}, 32'd0);
        run_txn("stat_int_txn", 0, 0, 5'h00, 32'h8000_0600, 0, 32'd0,
                32'h0000_0101, 32'h0000_0100, 32'h8000_0180, 0);
        chk("stat_int_cnt", {30'd0, stat_int}, 32'd1);
        chk("stat_exc_int", {30'd0, stat_exc}, 32'd0);
`endif

        bus.cp0_status = 32'd0;
        bus.cp0_cause  = 32'd0;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
